// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the memory-access stage.
//   WORD_W      : data/address word width
//   TIMEOUT     : number of WAIT cycles tolerated before a memory access is aborted
//   CNT_W       : width of the WAIT-cycle counter
//   mem_state_t : memory-access FSM states
package pipe_pkg;
  localparam int WORD_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = $clog2(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/MEM_WB_Reg.sv
// MEM/WB pipeline register.
//   clk, rst          : clock, asynchronous active-high reset (clears everything)
//   bubble            : load a bubble (control cleared, payload held)
//   ld_rdata          : capture rdata into wb_rm_data (load completing this cycle)
//   reg_write, mem_to_reg, alu_out, rdata, wr_addr : next-stage inputs
//   wb_*              : registered outputs toward write-back
module MEM_WB_Reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              ld_rdata,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] rdata,
  input  logic [4:0]        wr_addr,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_rm_data,
  output logic [4:0]        wb_wr_addr
);

  // MEM -> WB stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_alu_out    <= '0;
      wb_rm_data    <= '0;
      wb_wr_addr    <= '0;
    end else if (bubble) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
    end else begin
      wb_reg_write  <= reg_write;
      wb_mem_to_reg <= mem_to_reg;
      wb_alu_out    <= alu_out;
      wb_wr_addr    <= wr_addr;
      if (ld_rdata) wb_rm_data <= rdata;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues word loads/stores to data memory,
// stalls upstream while the memory is busy, aborts after TIMEOUT WAIT
// cycles, and feeds the MEM/WB register.
//   clk, rst                                : clock, asynchronous active-high reset
//   MEM_RegWrite/MemtoReg/MemWrite          : control from EX/MEM
//   MEM_ALUOut, MEM_wmData, MEM_wrAddr      : address/result, store data, dest reg
//   dm_req, dm_we, dm_addr, dm_wdata        : data-memory request
//   dm_rdata, dm_ready                      : data-memory response
//   mem_stall                               : freeze upstream stages
//   WB_*                                    : registered write-back payload
//   align_err, bus_err                      : one-cycle error pulses
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_MemWrite,
  input  logic [DATA_W-1:0] MEM_ALUOut,
  input  logic [DATA_W-1:0] MEM_wmData,
  input  logic [4:0]        MEM_wrAddr,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ready,
  output logic              mem_stall,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic [DATA_W-1:0] WB_ALUOut,
  output logic [DATA_W-1:0] WB_rmData,
  output logic [4:0]        WB_wrAddr,
  output logic              align_err,
  output logic              bus_err
);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic access, aligned, misaligned, abort, bubble, ld_rdata;

  assign access     = MEM_MemtoReg | MEM_MemWrite;
  assign aligned    = (MEM_ALUOut[1:0] == 2'b00);
  assign misaligned = access & ~aligned & (state == IDLE);
  assign abort      = (state == WAIT) & ~dm_ready & (cnt == CNT_W'(TIMEOUT - 1));

  // Gated by rst so an in-flight request vanishes the moment reset is
  // applied, even though the EX/MEM inputs may still show the access.
  assign dm_req    = ~rst & ((state == WAIT) | (access & aligned));
  assign mem_stall = dm_req & ~dm_ready & ~abort;

  // Address/data come straight from EX/MEM; the stall keeps them stable.
  assign dm_we    = dm_req & MEM_MemWrite;
  assign dm_addr  = MEM_ALUOut;
  assign dm_wdata = MEM_wmData;

  // Abort and misalignment retire as bubbles; stores never write a register.
  assign bubble   = mem_stall | abort | misaligned;
  assign ld_rdata = MEM_MemtoReg & dm_req & dm_ready;

  // Access FSM, WAIT-cycle counter and registered error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      align_err <= misaligned;
      bus_err   <= abort;
      case (state)
        IDLE: begin
          if (mem_stall) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (dm_ready | abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  MEM_WB_Reg #(.DATA_W(DATA_W)) u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .bubble       (bubble),
    .ld_rdata     (ld_rdata),
    .reg_write    (MEM_RegWrite & ~MEM_MemWrite),
    .mem_to_reg   (MEM_MemtoReg),
    .alu_out      (MEM_ALUOut),
    .rdata        (dm_rdata),
    .wr_addr      (MEM_wrAddr),
    .wb_reg_write (WB_RegWrite),
    .wb_mem_to_reg(WB_MemtoReg),
    .wb_alu_out   (WB_ALUOut),
    .wb_rm_data   (WB_rmData),
    .wb_wr_addr   (WB_wrAddr)
  );

endmodule
